alu2_result_collector: RTL

//  Downstream capture stage for the 10-in/6-out combinational ALU.
//  - Accepts each 6-bit ALU result (po0..po5) under a valid/ready handshake.
//  - Buffers results in a small synchronous FIFO and replays them to the consumer in order.
//  - Keeps sticky per-bit flags for all accepted results.
//  - Optionally keeps a MISR signature for in-system checking.

---
 rtl/alu2_result_collector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu2_result_collector.sv
// alu2_result_collector: capture stage behind the 6-output ALU.
// Accepts results under valid/ready, buffers them in a small FIFO and replays them in order.
// It also keeps sticky OR flags of every accepted result.
// Optional MISR signature, enabled by defining ALU2_COLLECT_MISR_EN; otherwise sig reads 16'h0000.

module alu2_result_collector #(
  parameter int unsigned RES_W = 6,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic [CNT_W-1:0] count,
  output logic [RES_W-1:0] sticky,
  output logic [15:0]      sig
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e           state_q, state_d;
  logic [RES_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RES_W-1:0] sticky_q;
  logic             push, pop;

  // Handshake flags come from registered state only; clr wins over both transfers.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready & ~clr;
  assign pop       = out_valid & out_ready & ~clr;
  assign out_res   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign sticky    = sticky_q;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + OneCnt;
    end else if (pop && !push) begin
      count_d = count_q - OneCnt;
    end
  end

  // Fill-level FSM next-state, tracking count.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) state_d = StPartial;
        end
        StPartial: begin
          if (push && !pop && (count_q == FullCnt - OneCnt)) begin
            state_d = StFull;
          end else if (pop && !push && (count_q == OneCnt)) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) state_d = StPartial;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State, count and pointer registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage array; reset to zero so out_res reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_res;
    end
  end

  // Sticky OR of every accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (clr) begin
      sticky_q <= '0;
    end else if (push) begin
      sticky_q <= sticky_q | in_res;
    end
  end

`ifdef ALU2_COLLECT_MISR_EN
  logic [15:0] sig_q;
  logic        fb;

  assign fb  = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
  assign sig = sig_q;

  // MISR folds each accepted result into the signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 16'hFFFF;
    end else if (clr) begin
      sig_q <= 16'hFFFF;
    end else if (push) begin
      sig_q <= {sig_q[14:0], fb} ^ {{(16 - RES_W){1'b0}}, in_res};
    end
  end
`else
  assign sig = 16'h0000;
`endif

endmodule
